// File: rtl/switch_debounce4_if.sv
// Signal bundle between the four-channel switch conditioner and its environment.
// Raw levels and the prescale strobe go in; clean levels and change strobes come out.
interface switch_debounce4_if;
    logic       tick_en;
    logic [3:0] sw_raw;
    logic [3:0] sw_clean;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    modport master (
        output tick_en,
        output sw_raw,
        input  sw_clean,
        input  rise,
        input  fall,
        input  changed
    );

    modport slave (
        input  tick_en,
        input  sw_raw,
        output sw_clean,
        output rise,
        output fall,
        output changed
    );
endinterface

// File: rtl/switch_debounce4.sv
// Four-channel switch debouncer: 2-flop synchronizer plus per-channel stability counter,
// producing clean levels for the ones-counter stage and registered rise/fall/changed strobes.
module switch_debounce4 #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    switch_debounce4_if.slave  sw_if
);

    localparam int unsigned NCH = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0]            sync1_q, sync2_q;
    logic [NCH-1:0]            clean_q, clean_d;
    logic [NCH-1:0]            rise_q, rise_d;
    logic [NCH-1:0]            fall_q, fall_d;
    logic                      changed_q, changed_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Per-channel stability counting; returning to the clean level restarts the run
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (!sw_if.tick_en) begin
                cnt_d[i] = cnt_q[i];
            end else if (cnt_q[i] == CNT_LAST) begin
                clean_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d    = clean_d & ~clean_q;
        fall_d    = ~clean_d & clean_q;
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= sw_if.sw_raw;
            sync2_q   <= sync1_q;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_if.sw_clean = clean_q;
    assign sw_if.rise     = rise_q;
    assign sw_if.fall     = fall_q;
    assign sw_if.changed  = changed_q;

endmodule

// File: tb/tb_switch_debounce4.sv
// Self-checking bench for switch_debounce4 (DEBOUNCE_CYCLES=4, CNT_W=2): directed sequences,
// a vector table, a popcount sweep and randomized traffic against a run-length reference model.
module tb_switch_debounce4;

    localparam int DB = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    switch_debounce4_if sw_if ();

    switch_debounce4 #(.DEBOUNCE_CYCLES(DB), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw_if (sw_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] raw;
        logic       tick;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       chg;
    } vec_t;

    vec_t vecs[$];

    // Reference model: raw is seen two edges late; a channel flips after DB tick-enabled
    // consecutive edges on which the delayed sample disagrees with the clean level.
    logic [3:0] m_dly[2];
    int         m_run[4];
    logic [3:0] m_clean, m_rise, m_fall;
    logic       m_chg;

    function automatic void model_reset();
        m_dly[0] = '0;
        m_dly[1] = '0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_clean = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_chg   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [3:0] raw, input logic tick);
        logic [3:0] seen;
        logic [3:0] prev;
        seen     = m_dly[1];
        m_dly[1] = m_dly[0];
        m_dly[0] = raw;
        prev     = m_clean;
        for (int i = 0; i < 4; i++) begin
            if (seen[i] == m_clean[i]) begin
                m_run[i] = 0;
            end else if (tick) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == DB) begin
                    m_clean[i] = seen[i];
                    m_run[i]   = 0;
                end
            end
        end
        m_rise = m_clean & ~prev;
        m_fall = prev & ~m_clean;
        m_chg  = (m_clean != prev);
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] clean, input logic [3:0] rise,
                              input logic [3:0] fall, input logic chg);
        chk({tag, ".clean"}, sw_if.sw_clean, clean);
        chk({tag, ".rise"}, sw_if.rise, rise);
        chk({tag, ".fall"}, sw_if.fall, fall);
        chk({tag, ".changed"}, {3'b000, sw_if.changed}, {3'b000, chg});
    endtask

    // One clock: drive inputs, let the edge happen, then compare against the model
    task automatic step(input logic [3:0] raw, input logic tick);
        sw_if.sw_raw  = raw;
        sw_if.tick_en = tick;
        @(posedge clk);
        model_edge(raw, tick);
        #1;
        expect_out("model", m_clean, m_rise, m_fall, m_chg);
    endtask

    task automatic do_reset(input logic [3:0] raw, input int cycles);
        sw_if.sw_raw = raw;
        rst_n = 1'b0;
        #1;
        expect_out("reset_async", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        expect_out("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask

    function automatic void add_vec(input logic [3:0] raw, input logic tick, input logic [3:0] clean,
                                    input logic [3:0] rise, input logic [3:0] fall, input logic chg);
        vec_t v;
        v.raw = raw; v.tick = tick; v.clean = clean; v.rise = rise; v.fall = fall; v.chg = chg;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [3:0] cur;
        logic [3:0] bpat[11];
        logic       t;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b1;
        sw_if.sw_raw  = '0;
        sw_if.tick_en = 1'b1;

        // Settle to 1100, then flip every channel at once to 0011
        for (int k = 0; k < 7; k++)
            add_vec(4'b1100, 1'b1, (k >= 5) ? 4'b1100 : 4'b0000,
                    (k == 5) ? 4'b1100 : 4'b0000, 4'b0000, k == 5);
        for (int k = 0; k < 7; k++)
            add_vec(4'b0011, 1'b1, (k >= 5) ? 4'b0011 : 4'b1100,
                    (k == 5) ? 4'b0011 : 4'b0000, (k == 5) ? 4'b1100 : 4'b0000, k == 5);

        #2;
        // Reset with switches already pressed, then the clean press
        do_reset(4'b1111, 2);
        for (int k = 0; k < 7; k++) begin
            step(4'b1111, 1'b1);
            expect_out("press", (k >= 5) ? 4'b1111 : 4'b0000, (k == 5) ? 4'b1111 : 4'b0000,
                       4'b0000, k == 5);
        end

        do_reset(4'b0000, 2);
        foreach (vecs[i]) begin
            step(vecs[i].raw, vecs[i].tick);
            expect_out("table", vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].chg);
        end

        // Bounce: a single low sample restarts the run
        do_reset(4'b0000, 1);
        for (int k = 0; k < 11; k++) bpat[k] = 4'b0001;
        bpat[3] = 4'b0000;
        for (int k = 0; k < 11; k++) begin
            step(bpat[k], 1'b1);
            expect_out("bounce", (k >= 9) ? 4'b0001 : 4'b0000, (k == 9) ? 4'b0001 : 4'b0000,
                       4'b0000, k == 9);
        end

        // Prescale: tick every third cycle, update on the fourth ticked edge
        do_reset(4'b0000, 1);
        for (int k = 0; k < 15; k++) begin
            step(4'b0100, (k % 3) == 2);
            expect_out("prescale", (k >= 11) ? 4'b0100 : 4'b0000, (k == 11) ? 4'b0100 : 4'b0000,
                       4'b0000, k == 11);
        end

        // tick_en held low: no change, and the counter resumes cleanly afterwards
        for (int k = 0; k < 12; k++) begin
            step(4'b0000, 1'b0);
            expect_out("tick_low", 4'b0100, 4'b0000, 4'b0000, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 1'b1);
            expect_out("tick_resume", (k >= 3) ? 4'b0000 : 4'b0100, 4'b0000,
                       (k == 3) ? 4'b0100 : 4'b0000, k == 3);
        end

        // Reset mid-count discards the partial run
        do_reset(4'b0000, 1);
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 1'b1);
            expect_out("midcount_pre", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        end
        do_reset(4'b0001, 2);
        for (int k = 0; k < 7; k++) begin
            step(4'b0001, 1'b1);
            expect_out("midcount_post", (k >= 5) ? 4'b0001 : 4'b0000, (k == 5) ? 4'b0001 : 4'b0000,
                       4'b0000, k == 5);
        end

        // Sweep all codes; downstream ones-count must match the settled input
        for (int v = 0; v < 16; v++) begin
            repeat (8) step(4'(v), 1'b1);
            chk("sweep.clean", sw_if.sw_clean, 4'(v));
            chk("sweep.popcount", 4'($countones(sw_if.sw_clean)), 4'($countones(4'(v))));
        end

        // Randomized traffic with occasional resets
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) cur = cur ^ 4'($urandom_range(1, 15));
            t = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 599) == 0) do_reset(cur, 1);
            step(cur, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
